// File: rtl/array_pkg.sv
// Shared constants and controller state encoding for the 4x4 systolic array front end.
package array_pkg;

  localparam int N        = 4;
  localparam int FEED_CYC = 2 * N - 1;
  localparam int TW       = $clog2(FEED_CYC);
  localparam int KW       = $clog2(N);

  typedef enum logic [2:0] {
    LOAD  = 3'd0,
    CLR   = 3'd1,
    FEED  = 3'd2,
    FLUSH = 3'd3,
    DRAIN = 3'd4
  } feed_state_e;

endpackage

// File: rtl/array4x4_feeder_skew_lane.sv
// One skewed edge lane: picks the buffer entry for feed step t and opens the
// lane's N-cycle valid window starting at t = LANE.
module skew_lane
  import array_pkg::*;
#(
  parameter int LANE = 0,
  parameter int BW   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 feed_en_i,
  input  logic [TW-1:0]        t_i,
  input  logic signed [BW-1:0] entry_i [N],
  output logic signed [BW-1:0] data_o,
  output logic                 vld_o
);

  logic [TW-1:0]        rel_s;
  logic                 vld_d;
  logic signed [BW-1:0] data_d;
  logic                 vld_q;
  logic signed [BW-1:0] data_q;

  // t below LANE wraps rel_s past N-1, so one compare covers both window edges.
  always_comb begin
    rel_s  = t_i - TW'(LANE);
    vld_d  = feed_en_i && (rel_s < TW'(N));
    data_d = '0;
    if (vld_d) begin
      data_d = entry_i[rel_s[KW-1:0]];
    end else begin
      data_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign vld_o  = vld_q;
  assign data_o = data_q;

endmodule

// File: rtl/array4x4_feeder.sv
// Sequencer feeding one buffered A/B matrix pair into the 4x4 systolic array
// with diagonal skew, then sequencing accumulator clear, flush and drain.
module array4x4_feeder
  import array_pkg::*;
#(
  parameter int BW        = 16,
  parameter int FLUSH_CYC = 10,
  parameter int DRAIN_CYC = 17
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [BW-1:0] in_a_col [N],
  input  logic signed [BW-1:0] in_b_row [N],
  output logic signed [BW-1:0] west_in  [N],
  output logic [N-1:0]         west_vld,
  output logic signed [BW-1:0] north_in [N],
  output logic [N-1:0]         north_vld,
  output logic                 acc_clr,
  output logic                 out_phase,
  output logic                 busy,
  output logic                 done
);

  localparam int CMAX = (FLUSH_CYC > DRAIN_CYC) ? FLUSH_CYC : DRAIN_CYC;
  localparam int CW   = $clog2(CMAX + 1);

  feed_state_e          state_q, state_d;
  logic [KW-1:0]        k_q, k_d;
  logic [TW-1:0]        t_q, t_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 accept_s;
  logic                 feed_en_s;
  logic                 in_ready_q, busy_q, acc_clr_q, out_phase_q, done_q;

  // a_buf[r][k] holds A[r][k]; b_buf[c][k] holds B[k][c] so each lane sees one row.
  logic signed [BW-1:0] a_buf [N][N];
  logic signed [BW-1:0] b_buf [N][N];

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    t_d      = t_q;
    cnt_d    = cnt_q;
    accept_s = in_valid && in_ready_q;
    case (state_q)
      LOAD: begin
        if (accept_s) begin
          if (k_q == KW'(N - 1)) begin
            k_d     = '0;
            state_d = CLR;
          end else begin
            k_d = k_q + 1'b1;
          end
        end else begin
          k_d = k_q;
        end
      end
      CLR: begin
        t_d     = '0;
        state_d = FEED;
      end
      FEED: begin
        if (t_q == TW'(FEED_CYC - 1)) begin
          t_d     = '0;
          cnt_d   = '0;
          state_d = FLUSH;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      FLUSH: begin
        if (cnt_q == CW'(FLUSH_CYC - 1)) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (cnt_q == CW'(DRAIN_CYC - 1)) begin
          cnt_d   = '0;
          state_d = LOAD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  // Control outputs are registered from next-state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      k_q         <= '0;
      t_q         <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      acc_clr_q   <= 1'b0;
      out_phase_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      t_q         <= t_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= (state_d == LOAD);
      busy_q      <= (state_d != LOAD);
      acc_clr_q   <= (state_d == CLR);
      out_phase_q <= (state_d == DRAIN);
      done_q      <= (state_d == DRAIN) && (cnt_d == CW'(DRAIN_CYC - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (accept_s) begin
      for (int i = 0; i < N; i++) begin
        a_buf[i][k_q] <= in_a_col[i];
        b_buf[i][k_q] <= in_b_row[i];
      end
    end
  end

  assign feed_en_s = (state_d == FEED);

  for (genvar g = 0; g < N; g++) begin : g_lane
    skew_lane #(.LANE(g), .BW(BW)) u_west (
      .clk       (clk),
      .rst_n     (rst_n),
      .feed_en_i (feed_en_s),
      .t_i       (t_d),
      .entry_i   (a_buf[g]),
      .data_o    (west_in[g]),
      .vld_o     (west_vld[g])
    );
    skew_lane #(.LANE(g), .BW(BW)) u_north (
      .clk       (clk),
      .rst_n     (rst_n),
      .feed_en_i (feed_en_s),
      .t_i       (t_d),
      .entry_i   (b_buf[g]),
      .data_o    (north_in[g]),
      .vld_o     (north_vld[g])
    );
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign acc_clr   = acc_clr_q;
  assign out_phase = out_phase_q;
  assign done      = done_q;

endmodule
